ram32x3_arbiter: RTL

//  Round-robin controller that shares one single-port ram32x3 (32 words x 3 bits) between two requesters, A and B.

---
 rtl/ram32x3_arbiter_if.sv | 21 ++
 rtl/ram32x3_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/ram32x3_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ram32x3_arbiter_if : one requester's req/gnt command and read-return bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface ram32x3_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 3
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/ram32x3_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ram32x3_arbiter : clears a single-port RAM after reset, then round-robins
//                   one access per cycle between requesters A and B
// Rev 1.0
// ----------------------------------------------------------------------------
module ram32x3_arbiter #(
  parameter int                ADDR_W    = 5,
  parameter int                DATA_W    = 3,
  parameter int                RD_LAT    = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  ram32x3_arbiter_if.slave       a,
  ram32x3_arbiter_if.slave       b,
  output logic [ADDR_W-1:0]      ram_address,
  output logic [DATA_W-1:0]      ram_data,
  output logic                   ram_wren,
  input  wire logic [DATA_W-1:0] ram_q,
  output logic                   busy
);

  localparam logic [0:0]        c_st_clear = 1'b0;
  localparam logic [0:0]        c_st_run   = 1'b1;
  localparam logic [ADDR_W-1:0] c_cnt_max  = '1;

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_pri_a;
  logic [RD_LAT:0][1:0] r_tag;

  logic       w_run;
  logic       w_gnt_a;
  logic       w_gnt_b;
  logic [1:0] w_rd;

  // r_pri_a set means A wins a tie: B was the most recent grant (or reset)
  assign w_run   = (r_state == c_st_run);
  assign w_gnt_a = w_run & a.req & (~b.req | r_pri_a);
  assign w_gnt_b = w_run & b.req & (~a.req | ~r_pri_a);
  assign w_rd    = {w_gnt_b & ~b.we, w_gnt_a & ~a.we};

  assign a.gnt    = w_gnt_a;
  assign b.gnt    = w_gnt_b;
  assign busy     = ~w_run;
  assign a.rvalid = r_tag[RD_LAT][0];
  assign b.rvalid = r_tag[RD_LAT][1];
  assign a.rdata  = ram_q;
  assign b.rdata  = ram_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= c_st_clear;
      r_cnt       <= '0;
      r_pri_a     <= 1'b1;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
    end else begin
      case (r_state)
        c_st_clear: begin
          ram_address <= r_cnt;
          ram_data    <= CLEAR_VAL;
          ram_wren    <= 1'b1;
          if (r_cnt == c_cnt_max) begin
            r_state <= c_st_run;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (w_gnt_a) begin
            ram_address <= a.addr;
            ram_data    <= a.wdata;
            ram_wren    <= a.we;
            r_pri_a     <= 1'b0;
          end else if (w_gnt_b) begin
            ram_address <= b.addr;
            ram_data    <= b.wdata;
            ram_wren    <= b.we;
            r_pri_a     <= 1'b1;
          end else begin
            ram_wren <= 1'b0;
          end
        end
      endcase
    end
  end

  // Read-owner tags travel alongside the RAM access; stage RD_LAT lines up with ram_q
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tag <= '0;
    end else begin
      r_tag[0] <= w_rd;
      for (int i = 1; i <= RD_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

endmodule
`default_nettype wire
